usr_sequencer: RTL and testbench

USR_SEQUENCER -- requirements
Module: usr_sequencer

---
 rtl/usr_sequencer.sv | 152 +++++++++++++++
 tb/tb_usr_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_sequencer.sv
// usr_sequencer: command sequencer driving the mode/data/serial inputs of an
// external universal shift register. Accepts LOAD / SHR / SHL / SER commands
// over a valid/ready handshake and reports completion with a one-cycle done
// pulse, qualified by aborted when the command was cut short.
module usr_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             abort,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_par_in,
  output logic             sr_ser_in_left,
  output logic             sr_ser_in_right,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_SER  = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  op_t              op_q;
  op_t              op_in;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic             aborted_q, aborted_nx;
  logic             accept;

  assign op_in  = op_t'(cmd_op);
  assign accept = cmd_valid & cmd_ready;

  // State, remaining shift count and abort flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      aborted_q <= aborted_nx;
    end
  end

  // Command payload latch; held from one accept to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_LOAD;
      count_q <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
    end else if (accept) begin
      op_q    <= op_in;
      count_q <= cmd_count;
      data_q  <= cmd_data;
      fill_q  <= cmd_fill;
    end
  end

  // Next-state logic; the current cycle's load/shift always completes even
  // when abort is raised, abort only redirects the following state to DONE.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    aborted_nx   = aborted_q;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          aborted_nx = 1'b0;
          if (op_in == OP_LOAD || op_in == OP_SER) begin
            state_nx = S_LOAD;
          end else if (cmd_count != '0) begin
            state_nx     = S_SHIFT;
            remaining_nx = cmd_count;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_nx   = S_DONE;
          aborted_nx = 1'b1;
        end else if (op_q == OP_SER && count_q != '0) begin
          state_nx     = S_SHIFT;
          remaining_nx = count_q;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_SHIFT: begin
        if (remaining != '0) remaining_nx = remaining - ONE;
        if (abort) begin
          state_nx     = S_DONE;
          aborted_nx   = 1'b1;
          remaining_nx = '0;
        end else if (remaining <= ONE) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Moore output decode from state (plus latched op / abort flag).
  always_comb begin
    sr_mode   = 2'b00;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    cmd_ready = (state == S_IDLE);
    aborted   = (state == S_DONE) & aborted_q;
    unique case (state)
      S_LOAD:  sr_mode = 2'b11;
      S_SHIFT: sr_mode = (op_q == OP_SHL) ? 2'b10 : 2'b01;
      default: sr_mode = 2'b00;
    endcase
  end

  assign sr_par_in       = data_q;
  assign sr_ser_in_left  = fill_q;
  assign sr_ser_in_right = fill_q;

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed testbench for usr_sequencer with a behavioural model of the
// controlled universal shift register.
module tb_usr_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic             abort;
  logic [1:0]       sr_mode;
  logic [WIDTH-1:0] sr_par_in;
  logic             sr_ser_in_left;
  logic             sr_ser_in_right;
  logic             busy;
  logic             done;
  logic             aborted;

  logic [WIDTH-1:0] sr_model;

  int n_checks = 0;
  int n_fail   = 0;

  // Results captured by run_cmd
  int          r_loads, r_shr, r_shl, r_lat;
  logic        r_abt, r_bad_abt, r_bad_busy;
  logic [15:0] r_ser;
  logic [7:0]  r_par;

  usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_count       (cmd_count),
    .cmd_data        (cmd_data),
    .cmd_fill        (cmd_fill),
    .abort           (abort),
    .sr_mode         (sr_mode),
    .sr_par_in       (sr_par_in),
    .sr_ser_in_left  (sr_ser_in_left),
    .sr_ser_in_right (sr_ser_in_right),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Universal shift register driven by the sequencer outputs
  always @(posedge clk) begin
    case (sr_mode)
      2'b01:   sr_model <= {sr_ser_in_left, sr_model[WIDTH-1:1]};
      2'b10:   sr_model <= {sr_model[WIDTH-2:0], sr_ser_in_right};
      2'b11:   sr_model <= sr_par_in;
      default: sr_model <= sr_model;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, then monitor until done (bounded), recording mode
  // cycles, latency from the accept edge, serial-out bits and abort status.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt,
                         input logic [7:0] data, input logic fill,
                         input int abort_at);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    check("ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid  = 1'b0;
    r_loads    = 0;
    r_shr      = 0;
    r_shl      = 0;
    r_lat      = -1;
    r_abt      = 1'b0;
    r_bad_abt  = 1'b0;
    r_bad_busy = 1'b0;
    r_ser      = '0;
    r_par      = '0;
    for (int k = 1; k <= 40; k++) begin
      case (sr_mode)
        2'b11: begin r_loads++; r_par = sr_par_in; end
        2'b01: begin r_ser[r_shr] = sr_model[0]; r_shr++; end
        2'b10: r_shl++;
        default: ;
      endcase
      if (!done && aborted) r_bad_abt = 1'b1;
      if (!busy) r_bad_busy = 1'b1;
      abort = (sr_mode == 2'b01 || sr_mode == 2'b10) && ((r_shr + r_shl) == abort_at);
      if (done) begin
        r_lat = k;
        r_abt = aborted;
        break;
      end
      tick();
    end
    abort = 1'b0;
    if (r_lat < 0) check("done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = '0;
    cmd_fill  = 1'b0;
    abort     = 1'b0;
    #1;
    // Reset state
    check("rst_mode",    sr_mode, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_ready",   cmd_ready, 1);
    check("rst_par_in",  sr_par_in, 0);
    check("rst_ser_l",   sr_ser_in_left, 0);
    check("rst_ser_r",   sr_ser_in_right, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_done",    done, 0);
    check("idle_abort_busy",    busy, 0);
    check("idle_abort_aborted", aborted, 0);

    // LOAD A5
    run_cmd(2'b00, 4'd0, 8'hA5, 1'b0, -1);
    check("load_cycles",  r_loads, 1);
    check("load_par",     r_par, 8'hA5);
    check("load_latency", r_lat, 2);
    check("load_aborted", r_abt, 0);
    check("load_shifts",  r_shr + r_shl, 0);
    check("load_busy",    r_bad_busy, 0);
    check("load_reg",     sr_model, 8'hA5);

    // Preload 01, then SHL count=3 fill=1
    run_cmd(2'b00, 4'd0, 8'h01, 1'b0, -1);
    check("preload_reg", sr_model, 8'h01);
    run_cmd(2'b10, 4'd3, 8'h00, 1'b1, -1);
    check("shl_shifts",  r_shl, 3);
    check("shl_shr",     r_shr, 0);
    check("shl_loads",   r_loads, 0);
    check("shl_latency", r_lat, 4);
    check("shl_reg",     sr_model, 8'h0F);
    check("shl_aborted", r_abt, 0);
    check("hold_idle_mode", sr_mode, 0);

    // SER C3 count=8 fill=0
    run_cmd(2'b11, 4'd8, 8'hC3, 1'b0, -1);
    check("ser_loads",   r_loads, 1);
    check("ser_shifts",  r_shr, 8);
    check("ser_shl",     r_shl, 0);
    check("ser_out_seq", r_ser[7:0], 8'hC3);
    check("ser_latency", r_lat, 10);
    check("ser_reg",     sr_model, 8'h00);
    check("ser_bad_abt", r_bad_abt, 0);

    // SHR count=0
    run_cmd(2'b01, 4'd0, 8'h00, 1'b1, -1);
    check("shr0_modes",   r_loads + r_shr + r_shl, 0);
    check("shr0_latency", r_lat, 1);
    check("shr0_aborted", r_abt, 0);

    // SHR count=10 aborted during the 4th shift
    run_cmd(2'b01, 4'd10, 8'h00, 1'b1, 4);
    check("abt_shifts",  r_shr, 4);
    check("abt_latency", r_lat, 5);
    check("abt_aborted", r_abt, 1);
    check("abt_bad_abt", r_bad_abt, 0);
    check("abt_reg",     sr_model, 8'hF0);
    check("abt_after_done",    done, 0);
    check("abt_after_aborted", aborted, 0);

    // Reset during the 2nd shift of a count=5 command
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 4'd5;
    cmd_data  = 8'h77;
    cmd_fill  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rstmid_pre_mode", sr_mode, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_mode",  sr_mode, 0);
    check("rstmid_busy",  busy, 0);
    check("rstmid_ready", cmd_ready, 1);
    check("rstmid_done",  done, 0);
    check("rstmid_par",   sr_par_in, 0);
    check("rstmid_fill",  sr_ser_in_left, 0);
    tick();
    check("rstmid_hold_done", done, 0);
    rst = 1'b0;
    run_cmd(2'b00, 4'd0, 8'h3C, 1'b0, -1);
    check("post_rst_loads",   r_loads, 1);
    check("post_rst_par",     r_par, 8'h3C);
    check("post_rst_latency", r_lat, 2);

    // cmd_valid held while busy: second command accepted after done
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 4'd2;
    cmd_data  = 8'h00;
    cmd_fill  = 1'b0;
    tick();
    cmd_op    = 2'b00;
    cmd_data  = 8'h5A;
    check("hold_k1_ready", cmd_ready, 0);
    check("hold_k1_mode",  sr_mode, 2'b01);
    tick();
    tick();
    check("hold_k3_done",  done, 1);
    check("hold_k3_mode",  sr_mode, 0);
    tick();
    check("hold_k4_ready", cmd_ready, 1);
    check("hold_k4_busy",  busy, 0);
    tick();
    cmd_valid = 1'b0;
    check("hold_k5_mode",  sr_mode, 2'b11);
    check("hold_k5_par",   sr_par_in, 8'h5A);
    tick();
    check("hold_k6_done",  done, 1);
    tick();
    check("hold_k7_ready", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
